jolt160_mem_bridge: RTL and testbench

JOLT160_MEM_BRIDGE -- requirements
Module: jolt160_mem_bridge

---
 rtl/jolt160_mem_bridge.sv | 148 ++++++++++++++
 tb/tb_jolt160_mem_bridge.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jolt160_mem_bridge.sv
// Bridges a byte-addressed CPU port (8/16-bit accesses) onto a 16-bit word memory
// with byte-lane enables; unaligned 16-bit accesses are split into two word accesses.
module jolt160_mem_bridge #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_rdwr,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              data_acc_sz,
  input  logic              data_inout_we,
  input  logic [15:0]       write_data_in,
  output logic [15:0]       read_data_out,
  output logic              data_ready,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_byte_en,
  output logic              mem_we,
  output logic              mem_req,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        state_dbg
);

  // Handshakes: a CPU access is taken on a rising edge where req_rdwr=1 and
  // data_ready=1; a memory access is held (mem_req=1, all mem_* stable) until the
  // rising edge where mem_ack=1, which completes it. mem_ack without mem_req is ignored.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-2:0] WORD_INC = 1;

  state_t      state;
  logic        acc_odd;
  logic        acc_wide;
  logic        acc_write;
  logic [7:0]  acc_hi;
  logic [7:0]  rd_lo;
  logic        split;
  logic [1:0]  first_be;
  logic [15:0] first_wdata;
  logic [15:0] rd_single;

  assign split     = acc_wide & acc_odd;
  assign state_dbg = state;

  // Lane placement of the first (or only) word access, taken straight from the CPU inputs.
  always_comb begin
    first_be    = 2'b11;
    first_wdata = write_data_in;
    if (addr_in[0]) begin
      first_be    = 2'b10;
      first_wdata = {write_data_in[7:0], write_data_in[7:0]};
    end else if (!data_acc_sz) begin
      first_be    = 2'b01;
      first_wdata = {write_data_in[7:0], write_data_in[7:0]};
    end
  end

  always_comb begin
    rd_single = mem_rdata;
    if (!acc_wide) begin
      rd_single = {8'h00, (acc_odd ? mem_rdata[15:8] : mem_rdata[7:0])};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      data_ready    <= 1'b1;
      read_data_out <= 16'h0000;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_byte_en   <= 2'b00;
      mem_addr      <= '0;
      mem_wdata     <= 16'h0000;
      acc_odd       <= 1'b0;
      acc_wide      <= 1'b0;
      acc_write     <= 1'b0;
      acc_hi        <= 8'h00;
      rd_lo         <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (req_rdwr) begin
            state       <= ACC0;
            data_ready  <= 1'b0;
            acc_odd     <= addr_in[0];
            acc_wide    <= data_acc_sz;
            acc_write   <= data_inout_we;
            acc_hi      <= write_data_in[15:8];
            mem_req     <= 1'b1;
            mem_we      <= data_inout_we;
            mem_addr    <= addr_in[ADDR_W-1:1];
            mem_byte_en <= first_be;
            mem_wdata   <= first_wdata;
          end
        end
        ACC0: begin
          if (mem_ack) begin
            if (split) begin
              // Second half: next word (wrapping), low lane, carries the high data byte.
              state       <= ACC1;
              rd_lo       <= mem_rdata[15:8];
              mem_addr    <= mem_addr + WORD_INC;
              mem_byte_en <= 2'b01;
              mem_wdata   <= {acc_hi, acc_hi};
            end else begin
              state       <= DONE;
              mem_req     <= 1'b0;
              mem_we      <= 1'b0;
              mem_byte_en <= 2'b00;
              if (!acc_write) begin
                read_data_out <= rd_single;
              end
            end
          end
        end
        ACC1: begin
          if (mem_ack) begin
            state       <= DONE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_byte_en <= 2'b00;
            if (!acc_write) begin
              read_data_out <= {mem_rdata[7:0], rd_lo};
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          data_ready <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          data_ready <= 1'b1;
          mem_req    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jolt160_mem_bridge.sv
// Directed bench for jolt160_mem_bridge: a bench-side word memory answers mem_req,
// each scenario task checks transactions, read data and latency against hand values.
module tb_jolt160_mem_bridge;

  logic        clk;
  logic        reset;
  logic        req_rdwr;
  logic [15:0] addr_in;
  logic        data_acc_sz;
  logic        data_inout_we;
  logic [15:0] write_data_in;
  logic [15:0] read_data_out;
  logic        data_ready;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_en;
  logic        mem_we;
  logic        mem_req;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [1:0]  state_dbg;

  int checks;
  int failures;
  int stab_err;
  int rule_err;
  int lat;

  logic [15:0] mem_words [0:32767];
  logic [14:0] txn_addr[$];
  logic [1:0]  txn_be[$];
  logic [15:0] txn_wd[$];
  logic        txn_we[$];

  jolt160_mem_bridge #(.ADDR_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_rdwr      (req_rdwr),
    .addr_in       (addr_in),
    .data_acc_sz   (data_acc_sz),
    .data_inout_we (data_inout_we),
    .write_data_in (write_data_in),
    .read_data_out (read_data_out),
    .data_ready    (data_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_byte_en   (mem_byte_en),
    .mem_we        (mem_we),
    .mem_req       (mem_req),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .state_dbg     (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: issues one CPU access and plays the memory, acking after wait_cyc stall cycles.
  task automatic run_access(input logic sz, input logic we, input logic [15:0] addr,
                            input logic [15:0] wd, input int wait_cyc, input bit noise,
                            output int lat_o);
    int          waited;
    bit          in_txn;
    logic [14:0] f_addr;
    logic [1:0]  f_be;
    logic [15:0] f_wd;
    logic        f_we;
    txn_addr.delete(); txn_be.delete(); txn_wd.delete(); txn_we.delete();
    stab_err = 0; rule_err = 0; lat_o = -1; waited = 0; in_txn = 0;
    f_addr = '0; f_be = '0; f_wd = '0; f_we = 1'b0;
    @(negedge clk);
    req_rdwr = 1'b1; data_acc_sz = sz; data_inout_we = we; addr_in = addr;
    write_data_in = wd; mem_ack = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      req_rdwr = noise && (cyc % 2 == 0);
      if (noise) begin
        addr_in       = 16'($urandom_range(0, 65535));
        write_data_in = 16'($urandom_range(0, 65535));
        data_inout_we = 1'b1;
        data_acc_sz   = 1'b1;
      end
      mem_ack   = 1'b0;
      mem_rdata = 16'h5A5A;
      if (data_ready) begin
        lat_o    = cyc + 1;
        req_rdwr = 1'b0;
        break;
      end
      if (!mem_req && (mem_we || mem_byte_en != 2'b00)) rule_err++;
      if (mem_req) begin
        if (!in_txn) begin
          in_txn = 1; waited = 0;
          f_addr = mem_addr; f_be = mem_byte_en; f_wd = mem_wdata; f_we = mem_we;
        end else if (f_addr !== mem_addr || f_be !== mem_byte_en ||
                     f_wd !== mem_wdata || f_we !== mem_we) begin
          stab_err++;
        end
        if (waited == wait_cyc) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_words[mem_addr];
          txn_addr.push_back(mem_addr); txn_be.push_back(mem_byte_en);
          txn_wd.push_back(mem_wdata);  txn_we.push_back(mem_we);
          if (mem_we && mem_byte_en[0]) mem_words[mem_addr][7:0]  = mem_wdata[7:0];
          if (mem_we && mem_byte_en[1]) mem_words[mem_addr][15:8] = mem_wdata[15:8];
          in_txn = 0;
        end else begin
          waited++;
        end
      end
    end
    mem_ack = 1'b0; req_rdwr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_rdwr = 1'b0; addr_in = '0; data_acc_sz = 1'b0;
    data_inout_we = 1'b0; write_data_in = '0; mem_rdata = '0; mem_ack = 1'b0;
    #12;
    if (data_ready !== 1'b1) begin failures++; $display("FAIL reset_data_ready got=%0b exp=1", data_ready); end
    checks++;
    if (read_data_out !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", read_data_out); end
    checks++;
    if ({mem_req, mem_we, mem_byte_en} !== 4'b0000) begin
      failures++; $display("FAIL reset_mem_ctrl got=%b exp=0000", {mem_req, mem_we, mem_byte_en});
    end
    checks++;
    if (mem_addr !== 15'h0000 || mem_wdata !== 16'h0000) begin
      failures++; $display("FAIL reset_mem_addr_data got=%h/%h exp=0000/0000", mem_addr, mem_wdata);
    end
    checks++;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    if (state_dbg !== 2'd0 || data_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_idle got=%0d/%0b exp=0/1", state_dbg, data_ready);
    end
    checks++;
  endtask

  task automatic test_byte_read();
    run_access(1'b0, 1'b0, 16'h0003, 16'h0000, 0, 0, lat);
    if (txn_addr.size() !== 1) begin failures++; $display("FAIL bread_odd_count got=%0d exp=1", txn_addr.size()); end
    checks++;
    if (txn_addr[0] !== 15'h0001 || txn_be[0] !== 2'b10 || txn_we[0] !== 1'b0) begin
      failures++; $display("FAIL bread_odd_txn got=%h/%b/%b exp=0001/10/0", txn_addr[0], txn_be[0], txn_we[0]);
    end
    checks++;
    if (read_data_out !== 16'h00BE) begin failures++; $display("FAIL bread_odd_data got=%h exp=00be", read_data_out); end
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL bread_odd_latency got=%0d exp=3", lat); end
    checks++;
    run_access(1'b0, 1'b0, 16'h0002, 16'h0000, 0, 0, lat);
    if (txn_be[0] !== 2'b01 || read_data_out !== 16'h00EF) begin
      failures++; $display("FAIL bread_even got=%b/%h exp=01/00ef", txn_be[0], read_data_out);
    end
    checks++;
  endtask

  task automatic test_aligned_write();
    run_access(1'b1, 1'b1, 16'h0010, 16'h1234, 0, 0, lat);
    if (txn_addr.size() !== 1) begin failures++; $display("FAIL awrite_count got=%0d exp=1", txn_addr.size()); end
    checks++;
    if (txn_addr[0] !== 15'h0008 || txn_be[0] !== 2'b11 || txn_wd[0] !== 16'h1234 || txn_we[0] !== 1'b1) begin
      failures++;
      $display("FAIL awrite_txn got=%h/%b/%h/%b exp=0008/11/1234/1", txn_addr[0], txn_be[0], txn_wd[0], txn_we[0]);
    end
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL awrite_latency got=%0d exp=3", lat); end
    checks++;
    if (read_data_out !== 16'h00EF) begin failures++; $display("FAIL awrite_rdata_held got=%h exp=00ef", read_data_out); end
    checks++;
    if (rule_err !== 0) begin failures++; $display("FAIL awrite_idle_ctrl got=%0d exp=0", rule_err); end
    checks++;
  endtask

  task automatic test_byte_write();
    run_access(1'b0, 1'b1, 16'h0021, 16'h55C3, 0, 0, lat);
    if (txn_addr[0] !== 15'h0010 || txn_be[0] !== 2'b10 || txn_wd[0][15:8] !== 8'hC3) begin
      failures++; $display("FAIL bwrite_txn got=%h/%b/%h exp=0010/10/c3", txn_addr[0], txn_be[0], txn_wd[0][15:8]);
    end
    checks++;
    run_access(1'b1, 1'b0, 16'h0020, 16'h0000, 0, 0, lat);
    if (read_data_out !== 16'hC300) begin failures++; $display("FAIL bwrite_readback got=%h exp=c300", read_data_out); end
    checks++;
  endtask

  task automatic test_unaligned_read();
    run_access(1'b1, 1'b0, 16'h0005, 16'h0000, 0, 0, lat);
    if (txn_addr.size() !== 2) begin failures++; $display("FAIL uread_count got=%0d exp=2", txn_addr.size()); end
    checks++;
    if (txn_addr[0] !== 15'h0002 || txn_be[0] !== 2'b10 || txn_addr[1] !== 15'h0003 || txn_be[1] !== 2'b01) begin
      failures++;
      $display("FAIL uread_txns got=%h/%b,%h/%b exp=0002/10,0003/01", txn_addr[0], txn_be[0], txn_addr[1], txn_be[1]);
    end
    checks++;
    if (read_data_out !== 16'hBBAA) begin failures++; $display("FAIL uread_data got=%h exp=bbaa", read_data_out); end
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL uread_latency got=%0d exp=4", lat); end
    checks++;
  endtask

  task automatic test_wrap_write();
    run_access(1'b1, 1'b1, 16'hFFFF, 16'h5678, 0, 0, lat);
    if (txn_addr.size() !== 2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", txn_addr.size()); end
    checks++;
    if (txn_addr[0] !== 15'h7FFF || txn_be[0] !== 2'b10 || txn_wd[0][15:8] !== 8'h78) begin
      failures++; $display("FAIL wrap_first got=%h/%b/%h exp=7fff/10/78", txn_addr[0], txn_be[0], txn_wd[0][15:8]);
    end
    checks++;
    if (txn_addr[1] !== 15'h0000 || txn_be[1] !== 2'b01 || txn_wd[1][7:0] !== 8'h56) begin
      failures++; $display("FAIL wrap_second got=%h/%b/%h exp=0000/01/56", txn_addr[1], txn_be[1], txn_wd[1][7:0]);
    end
    checks++;
    run_access(1'b1, 1'b0, 16'hFFFF, 16'h0000, 0, 0, lat);
    if (read_data_out !== 16'h5678) begin failures++; $display("FAIL wrap_readback got=%h exp=5678", read_data_out); end
    checks++;
  endtask

  task automatic test_wait_states();
    run_access(1'b1, 1'b0, 16'h0004, 16'h0000, 5, 1, lat);
    if (stab_err !== 0 || txn_addr.size() !== 1) begin
      failures++; $display("FAIL wait_stable got=%0d/%0d exp=0/1", stab_err, txn_addr.size());
    end
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL wait_latency got=%0d exp=8", lat); end
    checks++;
    if (read_data_out !== 16'hAA11) begin failures++; $display("FAIL wait_data got=%h exp=aa11", read_data_out); end
    checks++;
    run_access(1'b1, 1'b0, 16'h0005, 16'h0000, 3, 1, lat);
    if (stab_err !== 0 || lat !== 10 || read_data_out !== 16'hBBAA) begin
      failures++; $display("FAIL wait_split got=%0d/%0d/%h exp=0/10/bbaa", stab_err, lat, read_data_out);
    end
    checks++;
  endtask

  task automatic test_stray_ack();
    bit bad;
    bad = 0;
    repeat (3) begin
      @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'hFFFF;
      @(negedge clk);
      if (mem_req || state_dbg != 2'd0 || !data_ready) bad = 1;
    end
    mem_ack = 1'b0;
    if (bad !== 1'b0 || read_data_out !== 16'hBBAA) begin
      failures++; $display("FAIL stray_ack got=%0b/%h exp=0/bbaa", bad, read_data_out);
    end
    checks++;
  endtask

  task automatic test_reset_mid_access();
    bit seen;
    @(negedge clk);
    req_rdwr = 1'b1; data_acc_sz = 1'b1; data_inout_we = 1'b1;
    addr_in = 16'h0101; write_data_in = 16'h9ABC; mem_ack = 1'b0;
    @(negedge clk); req_rdwr = 1'b0;
    if (mem_req !== 1'b1 || mem_addr !== 15'h0080 || mem_byte_en !== 2'b10 || mem_wdata[15:8] !== 8'hBC) begin
      failures++; $display("FAIL abort_acc0 got=%b/%h/%b/%h exp=1/0080/10/bc", mem_req, mem_addr, mem_byte_en, mem_wdata[15:8]);
    end
    checks++;
    mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0;
    if (state_dbg !== 2'd2 || mem_addr !== 15'h0081 || mem_byte_en !== 2'b01) begin
      failures++; $display("FAIL abort_acc1 got=%0d/%h/%b exp=2/0081/01", state_dbg, mem_addr, mem_byte_en);
    end
    checks++;
    #2 reset = 1'b0;
    #1;
    if (mem_req !== 1'b0 || data_ready !== 1'b1 || state_dbg !== 2'd0 || mem_byte_en !== 2'b00 || mem_we !== 1'b0) begin
      failures++; $display("FAIL abort_async got=%b/%b/%0d/%b/%b exp=0/1/0/00/0", mem_req, data_ready, state_dbg, mem_byte_en, mem_we);
    end
    checks++;
    if (read_data_out !== 16'h0000) begin failures++; $display("FAIL abort_rdata_cleared got=%h exp=0000", read_data_out); end
    checks++;
    @(negedge clk); @(negedge clk); reset = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_req) seen = 1;
    end
    if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_acc1 got=%0b exp=0", seen); end
    checks++;
    run_access(1'b0, 1'b0, 16'h0003, 16'h0000, 0, 0, lat);
    if (read_data_out !== 16'h00BE || lat !== 3 || txn_addr.size() !== 1) begin
      failures++; $display("FAIL abort_next_req got=%h/%0d/%0d exp=00be/3/1", read_data_out, lat, txn_addr.size());
    end
    checks++;
  endtask

  initial begin
    checks = 0; failures = 0; stab_err = 0; rule_err = 0; lat = 0;
    for (int i = 0; i < 32768; i++) mem_words[i] = 16'h0000;
    mem_words[1] = 16'hBEEF;
    mem_words[2] = 16'hAA11;
    mem_words[3] = 16'h22BB;
    test_reset();
    test_byte_read();
    test_aligned_write();
    test_byte_write();
    test_unaligned_read();
    test_wrap_write();
    test_wait_states();
    test_stray_ack();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so a stuck handshake cannot hang the run.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
